// File: rtl/evt_encoder.sv
// Registered event priority encoder: request lines are captured into a pending
// register, masked, and the winning channel index is presented with valid/ack.
module evt_encoder #(
  parameter int N          = 8,
  parameter int W          = 3,
  parameter int EDGE       = 1,
  parameter int HIGH_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overrun,
  output logic         state_dbg
);

  // Handshake: y is a presented event while valid=1 and stays frozen until the
  // cycle ack=1 is sampled with valid=1; ack while valid=0 has no effect.
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   x_q;
  logic [N-1:0]   set_t, clr_t, elig;
  logic [N-1:0]   pending_nxt;
  logic           overrun_nxt;
  logic [W-1:0]   win;
  logic [W-1:0]   y_nxt;

  assign valid     = (state == PRESENT);
  assign state_dbg = state;

  always_comb begin
    set_t = (EDGE != 0) ? (x & ~x_q) : x;
    clr_t = '0;
    for (int i = 0; i < N; i++) begin
      clr_t[i] = ack && valid && (y == W'(i));
    end
    // A fresh capture wins over the acknowledge clear on the same edge.
    pending_nxt = set_t | (pending & ~clr_t);
    overrun_nxt = overrun | ((EDGE != 0) && (|(set_t & pending & ~clr_t)));
    elig        = pending & mask & ~clr_t;
  end

  always_comb begin
    win = '0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) win = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig[i]) win = W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    case (state)
      IDLE: begin
        if (|elig) begin
          y_nxt     = win;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // x_q tracks x even in reset so lines held high do not look like edges.
  always_ff @(posedge clk) begin
    x_q <= x;
    if (reset) begin
      state   <= IDLE;
      y       <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      y       <= y_nxt;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_evt_encoder.sv
// Directed bench for evt_encoder: a cycle table for the default configuration
// plus hand sequences for lowest-first priority and level capture.
module tb_evt_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x, mask;
  logic       ack_a, ack_b, ack_c;

  logic [2:0] y_a, y_b, y_c;
  logic       v_a, v_b, v_c;
  logic [7:0] p_a, p_b, p_c;
  logic       o_a, o_b, o_c;
  logic       s_a, s_b, s_c;

  int passed = 0;
  int total  = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] x;
    logic [7:0] mask;
    logic       ack;
    logic       rst;
    logic [2:0] y;
    logic       v;
    logic [7:0] p;
    logic       o;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  evt_encoder #(.N(8), .W(3), .EDGE(1), .HIGH_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .x(x), .mask(mask), .ack(ack_a),
    .y(y_a), .valid(v_a), .pending(p_a), .overrun(o_a), .state_dbg(s_a)
  );

  evt_encoder #(.N(8), .W(3), .EDGE(1), .HIGH_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .x(x), .mask(mask), .ack(ack_b),
    .y(y_b), .valid(v_b), .pending(p_b), .overrun(o_b), .state_dbg(s_b)
  );

  evt_encoder #(.N(8), .W(3), .EDGE(0), .HIGH_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .x(x), .mask(mask), .ack(ack_c),
    .y(y_c), .valid(v_c), .pending(p_c), .overrun(o_c), .state_dbg(s_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step(input logic [7:0] xi, input logic [7:0] mi, input logic aa,
                      input logic ab, input logic ac, input logic ri);
    x = xi; mask = mi; ack_a = aa; ack_b = ab; ack_c = ac; reset = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] xi, input logic [7:0] mi, input logic ai, input logic ri,
                     input logic [2:0] ye, input logic ve, input logic [7:0] pe, input logic oe);
    vec_t v;
    v.x = xi; v.mask = mi; v.ack = ai; v.rst = ri;
    v.y = ye; v.v = ve; v.p = pe; v.o = oe;
    vq.push_back(v);
  endtask

  initial begin
    x = 8'h00; mask = 8'hFF; ack_a = 0; ack_b = 0; ack_c = 0; reset = 1;

    //   x      mask   ack rst  y  v  pending o
    add(8'h00, 8'hFF, 0, 1, 0, 0, 8'h00, 0);  // reset state
    add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h20, 0);  // pulse x[5]
    add(8'h00, 8'hFF, 0, 0, 5, 1, 8'h20, 0);
    add(8'h00, 8'hFF, 1, 0, 5, 0, 8'h00, 0);
    add(8'h4A, 8'hFF, 0, 0, 5, 0, 8'h4A, 0);  // x[1],x[3],x[6] together
    add(8'h00, 8'hFF, 0, 0, 6, 1, 8'h4A, 0);
    add(8'h00, 8'hFF, 1, 0, 6, 0, 8'h0A, 0);
    add(8'h00, 8'hFF, 0, 0, 3, 1, 8'h0A, 0);
    add(8'h00, 8'hFF, 1, 0, 3, 0, 8'h02, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 1, 8'h02, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 1, 0, 8'h00, 0);  // ack while idle ignored
    add(8'h40, 8'hBF, 0, 0, 1, 0, 8'h40, 0);  // masked x[6]
    add(8'h00, 8'hBF, 0, 0, 1, 0, 8'h40, 0);
    add(8'h00, 8'hFF, 0, 0, 6, 1, 8'h40, 0);  // unmask
    add(8'h00, 8'hFF, 1, 0, 6, 0, 8'h00, 0);
    add(8'h04, 8'hFF, 0, 0, 6, 0, 8'h04, 0);  // x[2] then re-pulse
    add(8'h00, 8'hFF, 0, 0, 2, 1, 8'h04, 0);
    add(8'h04, 8'hFF, 0, 0, 2, 1, 8'h04, 1);
    add(8'h00, 8'hFF, 1, 0, 2, 0, 8'h00, 1);
    add(8'h00, 8'hFF, 0, 0, 2, 0, 8'h00, 1);  // single presentation, sticky
    add(8'h00, 8'hFF, 0, 1, 0, 0, 8'h00, 0);  // reset clears overrun
    add(8'h10, 8'hFF, 0, 0, 0, 0, 8'h10, 0);  // x[4] then rise during its ack
    add(8'h00, 8'hFF, 0, 0, 4, 1, 8'h10, 0);
    add(8'h10, 8'hFF, 1, 0, 4, 0, 8'h10, 0);
    add(8'h00, 8'hFF, 0, 0, 4, 1, 8'h10, 0);
    add(8'h00, 8'hFF, 1, 0, 4, 0, 8'h00, 0);
    add(8'h08, 8'hFF, 0, 0, 4, 0, 8'h08, 0);  // reset during ack
    add(8'h00, 8'hFF, 0, 0, 3, 1, 8'h08, 0);
    add(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    add(8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 0);  // lines high through reset
    add(8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    add(8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
    add(8'h80, 8'hFF, 0, 0, 0, 0, 8'h80, 0);  // mask after presentation
    add(8'h00, 8'hFF, 0, 0, 7, 1, 8'h80, 0);
    add(8'h00, 8'h00, 0, 0, 7, 1, 8'h80, 0);
    add(8'h00, 8'h00, 1, 0, 7, 0, 8'h00, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].x, vq[i].mask, vq[i].ack, 1'b0, 1'b0, vq[i].rst);
      check($sformatf("row%0d y", i),       32'(y_a), 32'(vq[i].y));
      check($sformatf("row%0d valid", i),   32'(v_a), 32'(vq[i].v));
      check($sformatf("row%0d pending", i), 32'(p_a), 32'(vq[i].p));
      check($sformatf("row%0d overrun", i), 32'(o_a), 32'(vq[i].o));
      check($sformatf("row%0d state", i),   32'(s_a), 32'(vq[i].v));
    end

    // Lowest index first: same three channels come out as 1, 3, 6.
    step(8'h00, 8'hFF, 0, 0, 0, 1);
    check("lo reset valid", 32'(v_b), 32'd0);
    step(8'h4A, 8'hFF, 0, 0, 0, 0);
    check("lo pending", 32'(p_b), 32'h4A);
    check("lo valid early", 32'(v_b), 32'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd6);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      step(8'h00, 8'hFF, 0, 0, 0, 0);
      check($sformatf("lo order%0d valid", k), 32'(v_b), 32'd1);
      check($sformatf("lo order%0d y", k),     32'(y_b), 32'(e));
      step(8'h00, 8'hFF, 0, 1, 0, 0);
      check($sformatf("lo order%0d ack", k),   32'(v_b), 32'd0);
    end
    check("lo pending drained", 32'(p_b), 32'h00);
    check("lo queue empty", 32'(exp_q.size()), 32'd0);

    // Level capture: lines held high through reset release.
    step(8'hFF, 8'hFF, 0, 0, 0, 1);
    check("lvl reset pending", 32'(p_c), 32'h00);
    step(8'hFF, 8'hFF, 0, 0, 0, 0);
    check("lvl edge1 pending", 32'(p_c), 32'hFF);
    check("lvl edge1 valid", 32'(v_c), 32'd0);
    step(8'hFF, 8'hFF, 0, 0, 0, 0);
    check("lvl edge2 valid", 32'(v_c), 32'd1);
    check("lvl edge2 y", 32'(y_c), 32'd7);
    step(8'hFF, 8'hFF, 0, 0, 1, 0);
    check("lvl ack valid", 32'(v_c), 32'd0);
    check("lvl ack pending", 32'(p_c), 32'hFF);
    step(8'hFF, 8'hFF, 0, 0, 0, 0);
    check("lvl repeat valid", 32'(v_c), 32'd1);
    check("lvl repeat y", 32'(y_c), 32'd7);
    check("lvl overrun", 32'(o_c), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
